// File: rtl/tx_burst_shaper.sv
// tx_burst_shaper: gates I/Q into ramp-up / full-scale / ramp-down bursts plus a zero guard.
// Define TX_BURST_SHAPER_ROUND_EN to round ramp products half up instead of truncating.
module tx_burst_shaper #(
    parameter int WIDTH            = 16,
    parameter int RAMP_LOG2        = 4,
    parameter int MAX_WINDOW_WIDTH = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        clk_enable,
    input  logic [MAX_WINDOW_WIDTH-1:0] TX_GUARD_LEN,
    input  logic                        start,
    input  logic                        stop,
    input  logic signed [WIDTH-1:0]     I_tdata,
    input  logic                        I_tvalid,
    input  logic signed [WIDTH-1:0]     Q_tdata,
    input  logic                        Q_tvalid,
    output logic signed [WIDTH-1:0]     I_out_tdata,
    output logic signed [WIDTH-1:0]     Q_out_tdata,
    output logic                        out_tvalid,
    output logic                        tx_busy
);

    typedef enum logic [2:0] {
        IDLE,
        RAMP_UP,
        HOLD,
        RAMP_DOWN,
        GUARD
    } state_t;

    localparam int PW = WIDTH + RAMP_LOG2 + 1;
    localparam logic [RAMP_LOG2-1:0]        K_MAX = '1;
    localparam logic [RAMP_LOG2-1:0]        K_ONE = RAMP_LOG2'(1);
    localparam logic [MAX_WINDOW_WIDTH-1:0] G_ONE = MAX_WINDOW_WIDTH'(1);
`ifdef TX_BURST_SHAPER_ROUND_EN
    localparam logic signed [PW-1:0] BIAS = PW'(1) << (RAMP_LOG2 - 1);
`else
    localparam logic signed [PW-1:0] BIAS = '0;
`endif

    state_t                      state, state_nx;
    logic [RAMP_LOG2-1:0]        k, k_nx;
    logic [MAX_WINDOW_WIDTH-1:0] gcnt, gcnt_nx;
    logic [MAX_WINDOW_WIDTH-1:0] glen, glen_nx;
    logic                        accept;
    logic                        guard_go;
    logic signed [RAMP_LOG2:0]   gain;
    logic signed [PW-1:0]        prod_i, prod_q;
    logic signed [WIDTH-1:0]     ramp_i, ramp_q;
    logic signed [WIDTH-1:0]     shaped_i, shaped_q;

    assign accept  = clk_enable & I_tvalid & Q_tvalid;
    assign tx_busy = (state != IDLE);

    // Gain is 0..2^RAMP_LOG2-1, so the shifted product always fits WIDTH.
    assign gain   = {1'b0, k};
    assign prod_i = PW'(I_tdata) * PW'(gain) + BIAS;
    assign prod_q = PW'(Q_tdata) * PW'(gain) + BIAS;
    assign ramp_i = WIDTH'(prod_i >>> RAMP_LOG2);
    assign ramp_q = WIDTH'(prod_q >>> RAMP_LOG2);

    always_comb begin
        shaped_i = '0;
        shaped_q = '0;
        unique case (state)
            RAMP_UP, RAMP_DOWN: begin
                shaped_i = ramp_i;
                shaped_q = ramp_q;
            end
            HOLD: begin
                shaped_i = I_tdata;
                shaped_q = Q_tdata;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_nx = state;
        k_nx     = k;
        gcnt_nx  = gcnt;
        glen_nx  = glen;
        guard_go = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nx = RAMP_UP;
                    k_nx     = '0;
                end
            end
            RAMP_UP: begin
                // A stop repeats the last gain actually emitted.
                if (stop) begin
                    if (accept) begin
                        state_nx = RAMP_DOWN;
                    end else if (k != '0) begin
                        state_nx = RAMP_DOWN;
                        k_nx     = k - K_ONE;
                    end else begin
                        guard_go = 1'b1;
                    end
                end else if (accept) begin
                    if (k == K_MAX) state_nx = HOLD;
                    else            k_nx     = k + K_ONE;
                end
            end
            HOLD: begin
                if (stop) begin
                    state_nx = RAMP_DOWN;
                    k_nx     = K_MAX;
                end
            end
            RAMP_DOWN: begin
                if (accept) begin
                    if (k == '0) guard_go = 1'b1;
                    else         k_nx     = k - K_ONE;
                end
            end
            GUARD: begin
                if (accept) begin
                    if (gcnt + G_ONE == glen) state_nx = IDLE;
                    else                      gcnt_nx  = gcnt + G_ONE;
                end
            end
            default: state_nx = IDLE;
        endcase
        if (guard_go) begin
            k_nx = '0;
            if (TX_GUARD_LEN == '0) begin
                state_nx = IDLE;
            end else begin
                state_nx = GUARD;
                gcnt_nx  = '0;
                glen_nx  = TX_GUARD_LEN;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            k           <= '0;
            gcnt        <= '0;
            glen        <= '0;
            out_tvalid  <= 1'b0;
            I_out_tdata <= '0;
            Q_out_tdata <= '0;
        end else if (clk_enable) begin
            state      <= state_nx;
            k          <= k_nx;
            gcnt       <= gcnt_nx;
            glen       <= glen_nx;
            out_tvalid <= accept;
            if (accept) begin
                I_out_tdata <= shaped_i;
                Q_out_tdata <= shaped_q;
            end
        end
    end

endmodule

// File: tb/tb_tx_burst_shaper.sv
// tb_tx_burst_shaper: directed test-plan bursts plus randomized traffic
// checked every cycle against an arithmetic burst model.
module tb_tx_burst_shaper;

    localparam int W    = 16;
    localparam int R    = 2;
    localparam int D    = 4;
    localparam int KMAX = 3;
`ifdef TX_BURST_SHAPER_ROUND_EN
    localparam int EXP_RND = -1;
`else
    localparam int EXP_RND = -2;
`endif

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                ce = 1'b0;
    logic [7:0]          glen = 8'd0;
    logic                start = 1'b0;
    logic                stop = 1'b0;
    logic signed [W-1:0] idat = '0;
    logic signed [W-1:0] qdat = '0;
    logic                ivld = 1'b0;
    logic                qvld = 1'b0;
    logic signed [W-1:0] iout, qout;
    logic                ovld, busy;

    int n_chk = 0;
    int n_pass = 0;

    // Model: mode 0 idle, 1 up, 2 hold, 3 down, 4 guard
    int m_mode = 0, m_k = 0, m_cnt = 0, m_len = 0;
    int m_i = 0, m_q = 0;
    bit m_vld = 0;

    logic signed [31:0] got_i[$];
    logic signed [31:0] got_q[$];

    int e_full[$]  = '{0, 250, 500, 750, 1000, 1000, 1000, 1000, 1000, 1000,
                       750, 500, 250, 0, 0, 0, 0};
    int e_early[$] = '{0, 250, 250, 0, 0, 0, 0};
    int e_gap[$]   = '{0, 250, 500, 750, 1000, 1000, 750, 500, 250, 0, 0, 0, 0};

    tx_burst_shaper #(
        .WIDTH(W),
        .RAMP_LOG2(R),
        .MAX_WINDOW_WIDTH(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .clk_enable(ce),
        .TX_GUARD_LEN(glen),
        .start(start),
        .stop(stop),
        .I_tdata(idat),
        .I_tvalid(ivld),
        .Q_tdata(qdat),
        .Q_tvalid(qvld),
        .I_out_tdata(iout),
        .Q_out_tdata(qout),
        .out_tvalid(ovld),
        .tx_busy(busy)
    );

    always #5 clk = ~clk;

    // floor(x*k / 2^R), optionally with half-up rounding
    function automatic int shape(input int x, input int k);
        int n;
        int q;
        n = x * k;
`ifdef TX_BURST_SHAPER_ROUND_EN
        n = n + D / 2;
`endif
        q = n / D;
        if (n < 0 && (n % D) != 0) q = q - 1;
        return q;
    endfunction

    task automatic go_guard(input int len);
        if (len == 0) begin
            m_mode = 0;
        end else begin
            m_mode = 4;
            m_cnt  = 0;
            m_len  = len;
        end
    endtask

    task automatic model_step(input bit st, input bit sp, input bit c,
                              input bit acc, input int i, input int q,
                              input int len);
        if (rst) begin
            m_mode = 0; m_k = 0; m_cnt = 0; m_len = 0;
            m_i = 0; m_q = 0; m_vld = 0;
            return;
        end
        if (!c) return;
        m_vld = acc;
        case (m_mode)
            0: begin
                if (acc) begin m_i = 0; m_q = 0; end
                if (st) begin m_mode = 1; m_k = 0; end
            end
            1: begin
                if (acc) begin m_i = shape(i, m_k); m_q = shape(q, m_k); end
                if (sp) begin
                    if (acc) m_mode = 3;
                    else if (m_k > 0) begin m_mode = 3; m_k = m_k - 1; end
                    else go_guard(len);
                end else if (acc) begin
                    if (m_k == KMAX) m_mode = 2;
                    else m_k = m_k + 1;
                end
            end
            2: begin
                if (acc) begin m_i = i; m_q = q; end
                if (sp) begin m_mode = 3; m_k = KMAX; end
            end
            3: begin
                if (acc) begin
                    m_i = shape(i, m_k);
                    m_q = shape(q, m_k);
                    if (m_k == 0) go_guard(len);
                    else m_k = m_k - 1;
                end
            end
            default: begin
                if (acc) begin
                    m_i = 0; m_q = 0;
                    m_cnt = m_cnt + 1;
                    if (m_cnt == m_len) m_mode = 0;
                end
            end
        endcase
    endtask

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        n_chk = n_chk + 1;
        assert (obs === exp) begin
            n_pass = n_pass + 1;
        end else begin
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input bit st, input bit sp, input bit c,
                        input bit iv, input bit qv);
        @(negedge clk);
        start = st;
        stop  = sp;
        ce    = c;
        ivld  = iv;
        qvld  = qv;
        model_step(st, sp, c, c & iv & qv, int'(idat), int'(qdat), int'(glen));
        @(posedge clk);
        #1;
        check("vld", {31'b0, ovld}, {31'b0, m_vld});
        check("i", iout, m_i);
        check("q", qout, m_q);
        check("busy", {31'b0, busy}, (m_mode != 0) ? 1 : 0);
        if (c && ovld === 1'b1) begin
            got_i.push_back(iout);
            got_q.push_back(qout);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(0, 0, 1, 0, 0);
        rst = 1'b0;
        got_i.delete();
        got_q.delete();
    endtask

    task automatic cmp_seq(input string tag, input int exp[$]);
        check({tag, "_len"}, got_i.size(), exp.size());
        for (int j = 0; j < exp.size(); j++) begin
            check({tag, "_i"}, (j < got_i.size()) ? got_i[j] : 32'hx, exp[j]);
            check({tag, "_q"}, (j < got_q.size()) ? got_q[j] : 32'hx, -exp[j]);
        end
    endtask

    initial begin
        tick(0, 0, 1, 0, 0);
        do_reset();
        check("rst_vld", {31'b0, ovld}, 0);
        check("rst_i", iout, 0);
        check("rst_busy", {31'b0, busy}, 0);

        // full burst
        glen = 8'd3;
        idat = 16'sd1000;
        qdat = -16'sd1000;
        tick(1, 0, 1, 0, 0);
        for (int c = 0; c < 17; c++) tick(0, c == 9, 1, 1, 1);
        cmp_seq("full", e_full);
        check("full_idle", {31'b0, busy}, 0);

        // early stop
        do_reset();
        tick(1, 0, 1, 0, 0);
        for (int c = 0; c < 7; c++) tick(0, c == 1, 1, 1, 1);
        cmp_seq("early", e_early);
        check("early_idle", {31'b0, busy}, 0);

        // rounding, then reset mid-HOLD
        do_reset();
        idat = -16'sd5;
        qdat = 16'sd5;
        tick(1, 0, 1, 0, 0);
        tick(0, 0, 1, 1, 1);
        check("round_k0", iout, 0);
        tick(0, 0, 1, 1, 1);
        check("round_k1", iout, EXP_RND);
        for (int c = 0; c < 3; c++) tick(0, 0, 1, 1, 1);
        check("hold_busy", {31'b0, busy}, 1);
        check("hold_pass", iout, -5);
        rst = 1'b1;
        tick(0, 0, 1, 1, 1);
        rst = 1'b0;
        check("mid_rst_i", iout, 0);
        check("mid_rst_q", qout, 0);
        check("mid_rst_vld", {31'b0, ovld}, 0);
        check("mid_rst_busy", {31'b0, busy}, 0);
        idat = 16'sd1000;
        qdat = -16'sd1000;
        tick(1, 0, 1, 0, 0);
        tick(0, 0, 1, 1, 1);
        check("restart_k0", iout, 0);
        tick(0, 0, 1, 1, 1);
        check("restart_k1", iout, 250);

        // gaps, freeze and start during HOLD
        do_reset();
        tick(1, 0, 1, 0, 0);
        tick(0, 0, 1, 1, 1);
        tick(0, 0, 1, 1, 1);
        for (int c = 0; c < 3; c++) tick(0, 0, 0, 1, 1);
        check("freeze_vld", {31'b0, ovld}, 1);
        for (int c = 0; c < 3; c++) tick(0, 0, 1, 0, 1);
        check("gap_vld", {31'b0, ovld}, 0);
        tick(0, 0, 1, 1, 1);
        tick(0, 0, 1, 1, 1);
        tick(1, 0, 1, 1, 1);
        tick(0, 1, 1, 1, 1);
        for (int c = 0; c < 7; c++) tick(0, 0, 1, 1, 1);
        cmp_seq("gap", e_gap);
        check("gap_idle", {31'b0, busy}, 0);

        // zero guard, simultaneous start/stop in IDLE
        do_reset();
        glen = 8'd0;
        tick(1, 1, 1, 0, 0);
        check("ss_busy", {31'b0, busy}, 1);
        tick(0, 1, 1, 1, 1);
        check("zg_d0", iout, 0);
        tick(0, 0, 1, 1, 1);
        check("zg_d1", iout, 0);
        check("zg_idle", {31'b0, busy}, 0);

        // randomized traffic against the model
        do_reset();
        for (int c = 0; c < 800; c++) begin
            idat = W'($urandom);
            qdat = W'($urandom);
            if ($urandom_range(0, 15) == 0) glen = 8'($urandom_range(0, 5));
            rst = ($urandom_range(0, 99) == 0);
            tick($urandom_range(0, 5) == 0, $urandom_range(0, 9) == 0,
                 $urandom_range(0, 7) != 0, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 3) != 0);
        end
        rst = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
